// File: rtl/pulse_interval_meter.sv
// -----------------------------------------------------------------------------
// pulse_interval_meter
//
// Characterises the random pulse generator's output. It detects rising edges
// on pulse_in, measures the clock-cycle interval between successive edges and
// counts pulses. The last, minimum and maximum intervals are kept, and any
// one of them, or the pulse count, is read out through a select mux.
//
// Optional feature (compile-time macro PIM_AVG_EN):
//   When defined, adds avg_out, an exponential moving average of the captured
//   intervals (weight 1/8). When undefined, the port and its logic are absent.
//
// Parameters:
//   CNT_W   width of the interval timer and of the last/min/max registers
//   PCNT_W  width of the pulse counter
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   ena           measurement enable; low freezes all measurement state
//   pulse_in      pulse line, synchronous to clk
//   clear         synchronous clear; same effect as reset, beats an edge
//   sel           read select: 0 last, 1 min, 2 max, 3 pulse count
//   data_out      selected result (combinational mux of registers)
//   new_interval  one-cycle strobe: a new interval was captured
//   ovf           sticky: at least one interval saturated
//   avg_out       moving average of intervals (PIM_AVG_EN only)
// -----------------------------------------------------------------------------
module pulse_interval_meter #(
    parameter int CNT_W  = 16,
    parameter int PCNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             pulse_in,
    input  logic             clear,
    input  logic [1:0]       sel,
    output logic [CNT_W-1:0] data_out,
    output logic             new_interval,
    output logic             ovf
`ifdef PIM_AVG_EN
    ,
    output logic [CNT_W-1:0] avg_out
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,     // no edge seen since reset/clear
        ST_MEASURE,  // timer running
        ST_SAT       // timer stuck at all-ones
    } state_t;

    localparam logic [CNT_W-1:0]  TIMER_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  TIMER_MAX = '1;
    localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);

    state_t             r_state;
    logic               r_prev;
    logic [CNT_W-1:0]   r_timer;
    logic [CNT_W-1:0]   r_last;
    logic [CNT_W-1:0]   r_min;
    logic [CNT_W-1:0]   r_max;
    logic [PCNT_W-1:0]  r_pulse_cnt;
    logic               r_ovf;
    logic               r_new_interval;

    logic               w_edge;
    logic               w_capture;
    logic [CNT_W-1:0]   w_timer_inc;
    logic [CNT_W-1:0]   w_cnt_ext;

    // r_prev samples every cycle regardless of ena, so an edge that happens
    // while ena is low is consumed and not seen later.
    assign w_edge      = pulse_in & ~r_prev;
    assign w_timer_inc = r_timer + TIMER_ONE;

    // An interval is captured on an accepted edge after the first one.
    assign w_capture   = ena & ~clear & w_edge & (r_state != ST_IDLE);

    // Pulse count as seen through data_out: zero-extended, or truncated to
    // the low CNT_W bits when the counter is the wider of the two.
    generate
        if (PCNT_W >= CNT_W) begin : g_cnt_trunc
            assign w_cnt_ext = r_pulse_cnt[CNT_W-1:0];
        end else begin : g_cnt_zext
            assign w_cnt_ext = {{(CNT_W-PCNT_W){1'b0}}, r_pulse_cnt};
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others and simulation
    // matches the synthesized flops regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_prev         <= 1'b0;
            r_timer        <= '0;
            r_last         <= '0;
            r_min          <= TIMER_MAX;
            r_max          <= '0;
            r_pulse_cnt    <= '0;
            r_ovf          <= 1'b0;
            r_new_interval <= 1'b0;
        end else begin
            r_prev         <= pulse_in;
            r_new_interval <= 1'b0;
            if (clear) begin
                // Later assignment to r_prev overrides the sample above.
                r_state     <= ST_IDLE;
                r_prev      <= 1'b0;
                r_timer     <= '0;
                r_last      <= '0;
                r_min       <= TIMER_MAX;
                r_max       <= '0;
                r_pulse_cnt <= '0;
                r_ovf       <= 1'b0;
            end else if (ena) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_edge) begin
                            r_pulse_cnt <= r_pulse_cnt + PCNT_ONE;
                            r_timer     <= TIMER_ONE;
                            r_state     <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE, ST_SAT: begin
                        if (w_edge) begin
                            r_last         <= r_timer;
                            r_min          <= (r_timer < r_min) ? r_timer : r_min;
                            r_max          <= (r_timer > r_max) ? r_timer : r_max;
                            r_pulse_cnt    <= r_pulse_cnt + PCNT_ONE;
                            r_timer        <= TIMER_ONE;
                            r_state        <= ST_MEASURE;
                            r_new_interval <= 1'b1;
                            if (r_state == ST_SAT) begin
                                r_ovf <= 1'b1;
                            end
                        end else if (r_state == ST_MEASURE) begin
                            r_timer <= w_timer_inc;
                            if (w_timer_inc == TIMER_MAX) begin
                                r_state <= ST_SAT;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // NOTE: every output of an always_comb block gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        data_out = r_last;
        case (sel)
            2'd0:    data_out = r_last;
            2'd1:    data_out = r_min;
            2'd2:    data_out = r_max;
            default: data_out = w_cnt_ext;
        endcase
    end

    assign new_interval = r_new_interval;
    assign ovf          = r_ovf;

`ifdef PIM_AVG_EN
    // Exponential moving average, avg += (interval - avg) / 8, evaluated
    // signed one bit wider than the timer so a shrinking interval pulls the
    // average down. The first interval seeds the average directly.
    logic [CNT_W-1:0]   r_avg;
    logic               r_avg_seeded;
    logic signed [CNT_W:0] w_avg_diff;
    logic signed [CNT_W:0] w_avg_step;
    logic [CNT_W-1:0]   w_avg_next;

    assign w_avg_diff = $signed({1'b0, r_timer}) - $signed({1'b0, r_avg});
    assign w_avg_step = w_avg_diff >>> 3;
    assign w_avg_next = r_avg + w_avg_step[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_avg        <= '0;
            r_avg_seeded <= 1'b0;
        end else if (clear) begin
            r_avg        <= '0;
            r_avg_seeded <= 1'b0;
        end else if (w_capture) begin
            r_avg        <= r_avg_seeded ? w_avg_next : r_timer;
            r_avg_seeded <= 1'b1;
        end
    end

    assign avg_out = r_avg;
`endif

endmodule

// File: doc/pulse_interval_meter.md
Name: pulse_interval_meter

Overview:
Downstream consumer of the random pulse generator's pulse output (uio_out[0]). Detects rising edges on the pulse line, measures the clock-cycle interval between successive edges and counts pulses. Keeps last, minimum and maximum interval for on-chip characterisation of the generator's randomness. Results are read through a selectable output mux that drives the tile's uo_out/uio pins.

Parameters:
CNT_W, 16, width of the interval timer and of the last/min/max registers
PCNT_W, 8, width of the pulse counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
ena  input  1  measurement enable; low freezes all measurement state
pulse_in  input  1  pulse line from the generator, synchronous to clk
clear  input  1  synchronous clear of all measurement state
sel  input  2  read select: 0 last, 1 min, 2 max, 3 pulse count (zero-extended)
data_out  output  CNT_W  selected result, combinational mux of registers
new_interval  output  1  one-cycle strobe: a new interval was captured
ovf  output  1  sticky: at least one interval saturated

Behaviour:
- Edge detect: prev register samples pulse_in every cycle, independent of ena. edge = pulse_in & ~prev. A pulse held high for N cycles counts once.
- FSM states: IDLE (no edge since reset/clear), MEASURE, SAT.
  - IDLE: timer = 0. On edge (ena=1): pulse_cnt+1, timer <= 1, go to MEASURE. No capture, no strobe.
  - MEASURE: on non-edge cycle, timer+1. When timer reaches all-ones, go to SAT.
  - SAT: timer holds all-ones.
  - Edge in MEASURE or SAT: last <= timer; min <= min(min,timer); max <= max(max,timer); pulse_cnt+1 (wraps mod 2^PCNT_W); timer <= 1; state <= MEASURE; new_interval=1 on the next cycle. An edge in SAT also sets ovf.
- Interval definition: edges in cycles t0 and t1 give interval = t1 - t0. Pulses every cycle are impossible because edges need a low between them, so the minimum interval is 2.
- ena=0: timer, state and all result registers hold. Edges are ignored, and prev keeps sampling. Cycles spent with ena low are excluded from the interval.
- clear=1: acts regardless of ena and wins over a simultaneous edge, which is dropped. Effect is identical to reset.
- Reset / clear values: state IDLE, timer 0, last 0, min all-ones, max 0, pulse_cnt 0, ovf 0, new_interval 0, prev 0.
- data_out reflects updated registers in the same cycle new_interval is high. With sel=3, data_out = pulse_cnt zero-extended to CNT_W. If PCNT_W > CNT_W, data_out takes the low CNT_W bits.
- Reset assertion mid-interval discards the partial interval with no strobe.

Optional Feature:
PIM_AVG_EN
- Defined: adds output avg_out [CNT_W-1:0], an exponential moving average of intervals. The first captured interval loads avg directly. Each later capture: avg <= avg + ((interval - avg) >>> 3), computed signed in CNT_W+1 bits. avg_out updates in the same cycle as new_interval. Reset/clear value is 0.
- Undefined: avg_out port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then 1-cycle pulses every 7 cycles, 5 pulses -> four new_interval strobes; sel=0 reads 7; sel=3 reads 5; min = max = 7; ovf = 0.
- Edges with gaps 3, then 10, then 5 -> sel=1 reads 3, sel=2 reads 10, sel=0 reads 5.
- pulse_in held high 5 cycles, low 4, high again -> pulse_cnt +2; interval 9; a held-high pulse counts once.
- CNT_W=4, edges 20 cycles apart -> last = 15; ovf = 1 and stays 1 after a following 6-cycle interval (last = 6).
- Edges 10 cycles apart with ena low for 4 cycles in between -> interval 6. clear asserted in the same cycle as an edge -> all registers at reset values, state IDLE, no strobe.
- With PIM_AVG_EN: intervals 16 then 8 -> avg_out 16, then 15.
